// File: rtl/demux13.sv
// demux13: registered 1-to-3 steering stage with valid/ready handshake.
// One holding register carries the word and its destination. The producer
// is ready whenever the holder is empty or the holder's own consumer is
// taking the word this cycle. Words with select 11 are dropped, flagged on
// err for one cycle and counted in a saturating counter.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A raised valid and its data stay stable until that edge.
// Ready may depend on the far side's ready, but never on valid.
module demux13 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_a_data,
  output logic         out_a_valid,
  input  logic         out_a_ready,
  output logic [N-1:0] out_b_data,
  output logic         out_b_valid,
  input  logic         out_b_ready,
  output logic [N-1:0] out_c_data,
  output logic         out_c_valid,
  input  logic         out_c_ready,
  output logic         err,
  output logic [7:0]   err_count
);

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  logic         hold_valid_q, hold_valid_d;
  logic [1:0]   hold_sel_q,   hold_sel_d;
  logic [N-1:0] hold_data_q,  hold_data_d;
  logic         err_q,        err_d;
  logic [7:0]   err_count_q,  err_count_d;

  logic dst_ready;
  logic drain;
  logic accept;
  logic accept_good;
  logic accept_bad;

  // Pick the ready of whichever consumer the held word is bound for.
  always_comb begin
    dst_ready = 1'b0;
    case (hold_sel_q)
      SEL_A:   dst_ready = out_a_ready;
      SEL_B:   dst_ready = out_b_ready;
      SEL_C:   dst_ready = out_c_ready;
      default: dst_ready = 1'b0;
    endcase
  end

  assign drain       = hold_valid_q & dst_ready;
  assign in_ready    = rst_n & (~hold_valid_q | dst_ready);
  assign accept      = in_valid & in_ready;
  assign accept_good = accept & (in_sel != SEL_BAD);
  assign accept_bad  = accept & (in_sel == SEL_BAD);

  // Next-state for the holding register and the drop statistics.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_sel_d   = hold_sel_q;
    hold_data_d  = hold_data_q;
    err_d        = accept_bad;
    err_count_d  = err_count_q;
    if (drain) begin
      hold_valid_d = 1'b0;
    end
    if (accept_good) begin
      hold_valid_d = 1'b1;
      hold_sel_d   = in_sel;
      hold_data_d  = in_data;
    end
    if (accept_bad && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State register with synchronous active-low reset; a pending word is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_sel_q   <= SEL_A;
      hold_data_q  <= '0;
      err_q        <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_sel_q   <= hold_sel_d;
      hold_data_q  <= hold_data_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  // Only the addressed consumer sees the word; idle ports read zero.
  // Valids are also forced low while reset is held.
  assign out_a_valid = rst_n & hold_valid_q & (hold_sel_q == SEL_A);
  assign out_b_valid = rst_n & hold_valid_q & (hold_sel_q == SEL_B);
  assign out_c_valid = rst_n & hold_valid_q & (hold_sel_q == SEL_C);
  assign out_a_data  = out_a_valid ? hold_data_q : '0;
  assign out_b_data  = out_b_valid ? hold_data_q : '0;
  assign out_c_data  = out_c_valid ? hold_data_q : '0;
  assign err         = err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_demux13.sv
module tb_demux13;

  localparam int N = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_a_data, out_b_data, out_c_data;
  logic         out_a_valid, out_b_valid, out_c_valid;
  logic         out_a_ready, out_b_ready, out_c_ready;
  logic         err;
  logic [7:0]   err_count;

  demux13 #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_a_data(out_a_data), .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_b_data(out_b_data), .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
    .out_c_data(out_c_data), .out_c_valid(out_c_valid), .out_c_ready(out_c_ready),
    .err(err), .err_count(err_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // exp_q holds {port, data} for every accepted routable word, oldest first.
  // The block has a single holding slot, so the front entry is the one on
  // display; the producer may hand over a word when nothing is pending or
  // the pending word's consumer is ready.
  logic [33:0] exp_q[$];
  logic        err_exp = 1'b0;
  int          cnt_exp = 0;

  always @(negedge clk) begin
    logic [2:0]   v;
    logic [2:0]   rdy;
    logic [N-1:0] dat [3];
    logic         rdy_exp;
    int           p;
    v      = {out_c_valid, out_b_valid, out_a_valid};
    rdy    = {out_c_ready, out_b_ready, out_a_ready};
    dat[0] = out_a_data;
    dat[1] = out_b_data;
    dat[2] = out_c_data;
    check("err", err, err_exp);
    check("err_count", err_count, cnt_exp);
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_valids", v, 0);
      check("rst_data", dat[0] | dat[1] | dat[2], 0);
      exp_q.delete();
      err_exp = 1'b0;
      cnt_exp = 0;
    end else begin
      rdy_exp = (exp_q.size() == 0) || rdy[exp_q[0][33:32]];
      check("in_ready", in_ready, rdy_exp);
      check("one_valid", $countones(v) <= 1, 1);
      for (int x = 0; x < 3; x++) begin
        if (!v[x]) check($sformatf("idle_data_%0d", x), dat[x], 0);
      end
      check("present", |v, exp_q.size() != 0);
      if ((|v) && exp_q.size() != 0) begin
        p = v[0] ? 0 : (v[1] ? 1 : 2);
        check("port", p, exp_q[0][33:32]);
        check("data", dat[p], exp_q[0][31:0]);
        if (rdy[p]) void'(exp_q.pop_front());
      end
      err_exp = 1'b0;
      if (in_valid && rdy_exp) begin
        if (in_sel != 2'd3) begin
          exp_q.push_back({in_sel, in_data});
        end else begin
          err_exp = 1'b1;
          if (cnt_exp < 255) cnt_exp++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] sel, input logic [N-1:0] data);
    bit done = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: sel %0d data %0h not accepted", sel, data);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sel   = $urandom_range(0, 3);
    in_data  = $urandom;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ready(input logic a, input logic b, input logic c);
    out_a_ready = a;
    out_b_ready = b;
    out_c_ready = c;
  endtask

  bit rand_done;

  // ---------------- stimulus ----------------
  initial begin
    // Reset held two cycles while a word is offered.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'hDEADBEEF;
    set_ready(1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(2'd1, 32'hDEADBEEF);
    idle(2);

    // Streaming to A.
    for (int i = 1; i <= 4; i++) send(2'd0, i);
    idle(2);

    // Backpressure on C, then a queued A word accepted on the drain edge.
    set_ready(1, 1, 0);
    send(2'd2, 32'hAAAA0000);
    fork
      send(2'd0, 32'h5);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        out_c_ready = 1'b1;
      end
    join
    idle(2);

    // Invalid select: single drop, then saturation.
    send(2'd3, 32'h1234);
    idle(2);
    check("err_count_one", err_count, 1);
    for (int i = 0; i < 300; i++) send(2'd3, $urandom);
    idle(2);
    check("err_count_sat", err_count, 255);

    // Mixed destinations at full rate.
    send(2'd0, 32'h10);
    send(2'd1, 32'h20);
    send(2'd2, 32'h30);
    send(2'd0, 32'h40);
    idle(3);

    // Reset while a word for B is stalled; it must never come out.
    set_ready(1, 0, 1);
    send(2'd1, 32'hBBBB0001);
    idle(1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    out_b_ready = 1'b1;
    idle(4);

    // Random traffic with random consumer readiness.
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send($urandom_range(0, 3), $urandom);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          set_ready($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    set_ready(1, 1, 1);
    idle(5);
    check("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux13.md
Name: demux13

Overview:
- Registered 1-to-3 steering block with valid/ready handshake. The counterpart to the 3:1 result mux.
- Takes a single producer stream (data plus 2-bit destination select) and delivers each accepted word to exactly one of three consumers: A, B or C.
- Used between the core's store/request path and its three targets (data RAM, MMIO, timer).
- One-entry output holding register: 1-cycle latency, full throughput when the destination is ready.

Parameters:
- N, 32, data width of input and all three outputs.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_data  input  N  word to route
- in_sel  input  2  destination: 00=A, 01=B, 10=C, 11=invalid
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- out_a_data  output  N  data to consumer A
- out_a_valid  output  1  word pending for A
- out_a_ready  input  1  A accepts
- out_b_data  output  N  data to consumer B
- out_b_valid  output  1  word pending for B
- out_b_ready  input  1  B accepts
- out_c_data  output  N  data to consumer C
- out_c_valid  output  1  word pending for C
- out_c_ready  input  1  C accepts
- err  output  1  one-cycle pulse: an invalid-select word was dropped
- err_count  output  8  saturating count of dropped words

Behaviour:
- Reset is synchronous and active-low (rst_n=0 sampled on a clk edge).
  - Clears hold_valid, hold_sel=00, hold_data=0, err=0, err_count=0.
  - All out_*_valid are 0 and all out_*_data are 0 while in reset and on the cycle after.
- in_ready is reset-gated: in_ready = rst_n & (~hold_valid | dst_ready).
  - dst_ready is the out_x_ready of the output selected by hold_sel.
  - Combinational from the output readies; no combinational path from in_valid.
- Accept occurs on a clk edge with in_valid & in_ready.
  - in_sel in {00,01,10}: hold_data <= in_data, hold_sel <= in_sel, hold_valid <= 1.
  - in_sel = 11: no word is stored. hold_valid <= 0 if the current word drained, otherwise unchanged. err <= 1 for exactly one cycle. err_count increments, saturating at 255.
- Drain occurs when hold_valid & dst_ready. hold_valid clears unless a new valid-select word is accepted on the same edge.
  - Simultaneous drain and accept gives back-to-back transfers: one word per cycle, no bubble.
- Outputs:
  - out_x_valid = hold_valid & (hold_sel == x). At most one valid is high at any time.
  - out_x_data = hold_data when out_x_valid is 1, else all zeros.
- Latency: a word accepted at edge k is presented on its output from cycle k+1 onward.
- Stability: once out_x_valid rises, it and out_x_data hold stable until out_x_ready is sampled high. They are never withdrawn except by reset.
- Readiness of non-selected outputs has no effect (no head-of-line blocking from them).
- Ordering: words leave in acceptance order. A word bound for B waits behind a stalled word bound for A.
- Producer side: while in_valid=1 and in_ready=0, in_data and in_sel may change. Only the value present at the accepting edge is used.
- err is low on every cycle without a dropped word. err_count never wraps.
- Reset mid-transfer: a pending word is discarded, not delivered.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1, in_sel=01, in_data=0xDEADBEEF -> in_ready=0, all valids 0, all data 0, err_count=0. After release, the first accept presents 0xDEADBEEF on out_b the next cycle.
2. Streaming: out_a_ready=1 constantly; drive 4 words 0x1..0x4, sel=00, on consecutive cycles -> out_a_valid high 4 consecutive cycles delivering 0x1,0x2,0x3,0x4. in_ready stays 1. out_b and out_c valids stay 0.
3. Backpressure: accept 0xAAAA0000 to C with out_c_ready=0 for 3 cycles; out_a_ready=1, out_b_ready=1 throughout -> out_c_valid and data stable for 3 cycles. in_ready=0 during the stall. On out_c_ready=1, the word drains and a queued sel=00 word 0x5 is accepted on the same edge. 0x5 appears on out_a the next cycle.
4. Invalid select: one word with sel=11, data 0x1234 -> no output valid rises, err=1 for exactly one cycle, err_count=1. Then 300 consecutive sel=11 words -> err_count=255 and holds.
5. Mixed destinations: sequence A,B,C,A with values 0x10,0x20,0x30,0x40, all readies 1 -> each value appears on only its own port, one per cycle, in order. The other ports read 0.
6. Reset mid-stall: pending word on B with out_b_ready=0; assert rst_n=0 for 1 cycle -> out_b_valid=0 the next cycle. The word is never delivered after out_b_ready rises.
